// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// The response watchdog is enabled with MEM_REQ_ARBITER_TIMEOUT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDeliver
    } arb_state_t;

    localparam logic [31:0] MEM_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request strictly after `last`,
// wrapping modulo N.
module rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (!any && req[(int'(last) + i) % N]) begin
                any = 1'b1;
                idx = $clog2(N)'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one single-transaction memory port among N_REQ requesters.
// Define MEM_REQ_ARBITER_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_wr_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         resp_valid_o,
    input  logic [N_REQ-1:0]         resp_ready_i,
    output logic [DATA_W-1:0]        resp_rdata_o,
    output logic                     mem_wr_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_resp_valid_i,
    output logic                     mem_resp_ready_o,
    input  logic [DATA_W-1:0]        mem_rdata_i
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    arb_state_t        state;
    logic [IdxW-1:0]   gnt;
    logic [IdxW-1:0]   last;
    logic [DATA_W-1:0] rbuf;
    logic              pick_any;
    logic [IdxW-1:0]   pick_idx;

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req  (req_valid_i),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            gnt   <= '0;
            last  <= IdxW'(N_REQ - 1);
            rbuf  <= '0;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick_any) begin
                        gnt   <= pick_idx;
                        state <= StReq;
                    end
                end
                StReq: begin
                    // Requester withdrew before handshake: abandon without advancing `last`.
                    if (!req_valid_i[gnt]) begin
                        state <= StIdle;
                    end else if (mem_req_ready_i) begin
                        state <= StResp;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                StResp: begin
                    if (mem_resp_valid_i) begin
                        rbuf  <= mem_rdata_i;
                        state <= StDeliver;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
                    end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        rbuf  <= DATA_W'(MEM_ARB_TIMEOUT_DATA);
                        state <= StDeliver;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                StDeliver: begin
                    if (resp_ready_i[gnt]) begin
                        last  <= gnt;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        resp_rdata_o     = '0;
        mem_wr_o         = 1'b0;
        mem_addr_o       = '0;
        mem_wdata_o      = '0;
        mem_req_valid_o  = 1'b0;
        mem_resp_ready_o = 1'b0;
        unique case (state)
            StReq: begin
                mem_req_valid_o  = req_valid_i[gnt];
                req_ready_o[gnt] = mem_req_ready_i;
                mem_wr_o         = req_wr_i[gnt];
                mem_addr_o       = req_addr_i[int'(gnt)*ADDR_W +: ADDR_W];
                mem_wdata_o      = req_wdata_i[int'(gnt)*DATA_W +: DATA_W];
            end
            StResp:    mem_resp_ready_o = 1'b1;
            StDeliver: begin
                resp_valid_o[gnt] = 1'b1;
                resp_rdata_o      = rbuf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (N_REQ=4, TIMEOUT_CYCLES=8).
module tb_mem_req_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_wr_i = '0;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    resp_valid_o;
    logic [N-1:0]    resp_ready_i = '0;
    logic [DW-1:0]   resp_rdata_o;
    logic            mem_wr_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_req_valid_o;
    logic            mem_req_ready_i = 1'b1;
    logic            mem_resp_valid_i = 1'b0;
    logic            mem_resp_ready_o;
    logic [DW-1:0]   mem_rdata_i = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .N_REQ          (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_wr_i         (req_wr_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_rdata_o     (resp_rdata_o),
        .mem_wr_o         (mem_wr_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting from IDLE; resp_ready held low for `hold` DELIVER cycles.
    task automatic do_txn(input int exp, input logic [31:0] rd, input int hold);
        step();
        check("req_valid", 128'(mem_req_valid_o), 128'(1));
        check("req_ready", 128'(req_ready_o), 128'(4'b0001 << exp));
        check("mem_addr", 128'(mem_addr_o), 128'(16'h1234 + 16'(exp)));
        check("mem_wdata", 128'(mem_wdata_o), 128'(32'hA000_0000 + 32'(exp)));
        step();
        check("resp_ready", 128'(mem_resp_ready_o), 128'(1));
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = rd;
        step();
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = ~rd;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 128'(resp_valid_o), 128'(4'b0001 << exp));
            check("hold_rdata", 128'(resp_rdata_o), 128'(rd));
            check("hold_nogrant", 128'(mem_req_valid_o), 128'(0));
            // Stray downstream pulse outside RESP must not disturb the held data.
            if (i == 1) mem_resp_valid_i = 1'b1;
            step();
            mem_resp_valid_i = 1'b0;
        end
        check("deliver_valid", 128'(resp_valid_o), 128'(4'b0001 << exp));
        check("deliver_rdata", 128'(resp_rdata_o), 128'(rd));
        resp_ready_i = '1;
        step();
        resp_ready_i = '0;
        #1;
        check("after_deliver", 128'(resp_valid_o), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW]  = 16'h1234 + 16'(i);
            req_wdata_i[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
        step();
        check("rst_resp_valid", 128'(resp_valid_o), 128'(0));
        check("rst_mem_req_valid", 128'(mem_req_valid_o), 128'(0));
        check("rst_resp_ready", 128'(mem_resp_ready_o), 128'(0));
        rst = 1'b0;

        // Single requester read.
        req_valid_i = 4'b0001;
        do_txn(0, 32'hCAFE_F00D, 0);

        // All valid continuously: 0 already served, so 1,2,3,0,1.
        req_valid_i = 4'b1111;
        do_txn(1, 32'h1111_0001, 0);
        do_txn(2, 32'h2222_0002, 0);
        do_txn(3, 32'h3333_0003, 0);
        do_txn(0, 32'h0000_0004, 0);
        do_txn(1, 32'h1111_0005, 0);

        // last=1, requesters 1 and 3 -> 3 then 1.
        req_valid_i = 4'b1010;
        do_txn(3, 32'h3333_0006, 0);
        do_txn(1, 32'h1111_0007, 0);

        // Withdrawn request must not advance the pointer (last stays 1).
        req_valid_i     = 4'b0100;
        mem_req_ready_i = 1'b0;
        step();
        check("withdraw_grant", 128'(mem_req_valid_o), 128'(1));
        req_valid_i = 4'b0000;
        #1;
        check("withdraw_valid", 128'(mem_req_valid_o), 128'(0));
        step();
        mem_req_ready_i = 1'b1;
        req_valid_i     = 4'b0101;
        do_txn(2, 32'h2222_0008, 0);

        // Back-pressure on requester 2 for 5 cycles.
        req_valid_i = 4'b0100;
        do_txn(2, 32'h2222_0009, 5);

        // Reset during RESP.
        req_valid_i = 4'b0010;
        step();
        step();
        check("pre_rst_resp", 128'(mem_resp_ready_o), 128'(1));
        rst = 1'b1;
        #1;
        check("midrst_resp_ready", 128'(mem_resp_ready_o), 128'(0));
        check("midrst_outs", {mem_req_valid_o, req_ready_o, resp_valid_o, resp_rdata_o},
              128'(0));
        step();
        rst         = 1'b0;
        req_valid_i = 4'b1111;
        do_txn(0, 32'h0BAD_0010, 0);

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
        // Watchdog: no response for 8 RESP cycles.
        req_valid_i = 4'b0010;
        step();
        step();
        check("to_resp", 128'(mem_resp_ready_o), 128'(1));
        req_valid_i = 4'b0000;
        for (int i = 0; i < 7; i++) step();
        check("to_pending", 128'(resp_valid_o), 128'(0));
        step();
        check("to_valid", 128'(resp_valid_o), 128'(4'b0010));
        check("to_rdata", 128'(resp_rdata_o), 128'(32'hDEAD_BEEF));
        step();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'h5555_AAAA;
        step();
        mem_resp_valid_i = 1'b0;
        check("to_late_rdata", 128'(resp_rdata_o), 128'(32'hDEAD_BEEF));
        resp_ready_i = '1;
        step();
        resp_ready_i = '0;
        #1;
        check("to_done", 128'(resp_valid_o), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
